// File: rtl/mem_req_initiator_pkg.sv
// Shared definitions for mem_req_initiator: FSM encoding, request word layout and
// timeout counter sizing.
package mem_req_initiator_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Buffered request word: {wr, addr[15:0], wdata[15:0]}
    localparam int REQ_W = 33;

    // Counter width able to hold cycles-1
    function automatic int timeout_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_req_initiator_req_fifo.sv
// req_fifo: small request buffer for mem_req_initiator. Full/empty are derived from
// read/write pointers that carry one extra wrap bit.
module req_fifo
    import mem_req_initiator_pkg::*;
#(
    parameter int WIDTH = REQ_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; push is only ever issued when not full, pop only when not empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since empty gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: buffers pipeline load/store requests and issues them one at a time
// on the mem_system Rd/Wr/Done interface, returning data/hit/error as a one-cycle pulse.
// Optional feature macro: PERF_CNT_EN builds saturating hit/miss counters.
module mem_req_initiator
    import mem_req_initiator_pkg::*;
#(
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_hit,
    output logic        rsp_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_datain,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_dataout,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_cachehit,
    input  logic        mem_err,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int TO_W = timeout_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             cur_wr_q;
    logic [15:0]      addr_q;
    logic [15:0]      wdata_q;
    logic [15:0]      rdata_q;
    logic             hit_q;
    logic             err_q;
    logic [TO_W-1:0]  to_cnt_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [REQ_W-1:0] fifo_head;
    logic             push;
    logic             pop;
    logic             timed_out;
    logic             unused_stall;

    // Stall is informational only; the FSM waits purely on Done
    assign unused_stall = mem_stall;

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    assign pop       = (state_q == IDLE) && !fifo_empty;
    assign timed_out = (to_cnt_q == TO_LAST);

    req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({req_wr, req_addr, req_wdata}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Next-state: misaligned requests skip the bus; Done beats timeout in ACTIVE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = fifo_head[16] ? RESP : ACTIVE;
            ACTIVE:  if (mem_done || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus request/response capture and timeout counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_wr_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cur_wr_q <= fifo_head[32];
                addr_q   <= fifo_head[31:16];
                wdata_q  <= fifo_head[15:0];
                rdata_q  <= '0;
                hit_q    <= 1'b0;
                err_q    <= fifo_head[16];
                to_cnt_q <= '0;
            end else if (state_q == ACTIVE) begin
                if (mem_done) begin
                    rdata_q <= (cur_wr_q || mem_err) ? 16'h0000 : mem_dataout;
                    hit_q   <= mem_cachehit;
                    err_q   <= mem_err;
                end else if (timed_out) begin
                    hit_q <= 1'b0;
                    err_q <= 1'b1;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end
        end
    end

    // Bus and response outputs decoded from registered state only
    always_comb begin
        mem_rd     = (state_q == ACTIVE) && !cur_wr_q;
        mem_wr     = (state_q == ACTIVE) && cur_wr_q;
        mem_addr   = addr_q;
        mem_datain = wdata_q;
        rsp_valid  = (state_q == RESP);
        rsp_rdata  = rsp_valid ? rdata_q : 16'h0000;
        rsp_hit    = rsp_valid && hit_q;
        rsp_err    = rsp_valid && err_q;
    end

`ifdef PERF_CNT_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Saturating hit/miss counts over error-free responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rsp_valid && !err_q) begin
            if (hit_q) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed self-checking bench for mem_req_initiator (FIFO_DEPTH=2, TIMEOUT_CYCLES=64).
module tb_mem_req_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_hit;
    logic        rsp_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_datain;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_dataout;
    logic        mem_done;
    logic        mem_stall;
    logic        mem_cachehit;
    logic        mem_err;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int errors = 0;
    int checks = 0;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_req_initiator #(
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_hit      (rsp_hit),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_dataout  (mem_dataout),
        .mem_done     (mem_done),
        .mem_stall    (mem_stall),
        .mem_cachehit (mem_cachehit),
        .mem_err      (mem_err),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request for a single cycle; returns in the following cycle
    task automatic push(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_dataout  = '0;
        mem_done     = 1'b0;
        mem_stall    = 1'b0;
        mem_cachehit = 1'b0;
        mem_err      = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_hit_count", hit_count, 0);
        tick();
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);

        // 1: load 0x0010, Done after 3 cycles with 0xBEEF, miss
        push(1'b0, 16'h0010, 16'h0000);
        chk("t1_idle_rd", mem_rd, 0);
        tick();
        chk("t1_rd_c1", mem_rd, 1);
        chk("t1_addr", mem_addr, 16'h0010);
        tick();
        chk("t1_rd_c2", mem_rd, 1);
        tick();
        chk("t1_rd_c3", mem_rd, 1);
        tick();
        mem_done    = 1'b1;
        mem_dataout = 16'hBEEF;
        chk("t1_rd_done", mem_rd, 1);
        chk("t1_addr_done", mem_addr, 16'h0010);
        tick();
        mem_done = 1'b0;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rdata", rsp_rdata, 16'hBEEF);
        chk("t1_hit", rsp_hit, 0);
        chk("t1_err", rsp_err, 0);
        chk("t1_rd_resp", mem_rd, 0);
        tick();
        chk("t1_rsp_once", rsp_valid, 0);

        // 2: store 0x0022 <- 0x1234, Done after 1 cycle, hit
        push(1'b1, 16'h0022, 16'h1234);
        chk("t2_idle_wr", mem_wr, 0);
        tick();
        chk("t2_wr", mem_wr, 1);
        chk("t2_rd", mem_rd, 0);
        chk("t2_datain", mem_datain, 16'h1234);
        chk("t2_addr", mem_addr, 16'h0022);
        mem_done     = 1'b1;
        mem_cachehit = 1'b1;
        mem_dataout  = 16'hFFFF;
        tick();
        mem_done     = 1'b0;
        mem_cachehit = 1'b0;
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rdata", rsp_rdata, 0);
        chk("t2_hit", rsp_hit, 1);
        chk("t2_err", rsp_err, 0);
        chk("t2_wr_resp", mem_wr, 0);
        tick();
        chk("t2_hit_count", hit_count, PERF ? 1 : 0);
        chk("t2_miss_count", miss_count, PERF ? 1 : 0);

        // 3: back-to-back pushes A(ld 0100), B(ld 0102), C(st 0104); D refused while full
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0100; req_wdata = 16'h0000;
        tick();
        req_addr = 16'h0102;
        chk("t3_ready_b", req_ready, 1);
        tick();
        req_wr = 1'b1; req_addr = 16'h0104; req_wdata = 16'h5555;
        chk("t3_a_rd", mem_rd, 1);
        chk("t3_a_addr", mem_addr, 16'h0100);
        tick();
        req_addr = 16'h0106; req_wdata = 16'h6666;
        chk("t3_full_ready", req_ready, 0);
        tick();
        req_valid   = 1'b0;
        mem_done    = 1'b1;
        mem_dataout = 16'h0A0A;
        chk("t3_full_hold", req_ready, 0);
        tick();
        mem_done = 1'b0;
        chk("t3_a_rsp", rsp_valid, 1);
        chk("t3_a_rdata", rsp_rdata, 16'h0A0A);
        chk("t3_a_hit", rsp_hit, 0);
        chk("t3_gap1_rd", mem_rd, 0);
        tick();
        chk("t3_gap2_rd", mem_rd, 0);
        chk("t3_pop_ready", req_ready, 0);
        tick();
        chk("t3_b_rd", mem_rd, 1);
        chk("t3_b_addr", mem_addr, 16'h0102);
        chk("t3_b_ready", req_ready, 1);
        mem_done     = 1'b1;
        mem_cachehit = 1'b1;
        mem_dataout  = 16'h0B0B;
        tick();
        mem_done = 1'b0;
        chk("t3_b_rsp", rsp_valid, 1);
        chk("t3_b_rdata", rsp_rdata, 16'h0B0B);
        chk("t3_b_hit", rsp_hit, 1);
        tick();
        chk("t3_gap_b_wr", mem_wr, 0);
        chk("t3_gap_b_rd", mem_rd, 0);
        tick();
        chk("t3_c_wr", mem_wr, 1);
        chk("t3_c_addr", mem_addr, 16'h0104);
        chk("t3_c_datain", mem_datain, 16'h5555);
        mem_done = 1'b1;
        tick();
        mem_done     = 1'b0;
        mem_cachehit = 1'b0;
        chk("t3_c_rsp", rsp_valid, 1);
        chk("t3_c_rdata", rsp_rdata, 0);
        chk("t3_c_hit", rsp_hit, 1);
        tick();
        tick();
        chk("t3_no_d_wr", mem_wr, 0);
        chk("t3_no_d_rd", mem_rd, 0);
        chk("t3_no_d_rsp", rsp_valid, 0);

        // 4: misaligned load 0x0013 never touches the bus
        push(1'b0, 16'h0013, 16'h0000);
        chk("t4_pop_rd", mem_rd, 0);
        tick();
        chk("t4_rsp", rsp_valid, 1);
        chk("t4_err", rsp_err, 1);
        chk("t4_rdata", rsp_rdata, 0);
        chk("t4_rd", mem_rd, 0);
        tick();
        chk("t4_rsp_once", rsp_valid, 0);
        chk("t4_rd_after", mem_rd, 0);

        // 5: no Done -> timeout error 64 cycles after ACTIVE entry; CacheHit ignored
        mem_cachehit = 1'b1;
        push(1'b0, 16'h0030, 16'h0000);
        tick();
        n   = 0;
        bad = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            if (mem_rd !== 1'b1 || mem_addr !== 16'h0030) bad++;
            tick();
            n++;
        end
        chk("t5_latency", n, 64);
        chk("t5_stable", bad, 0);
        chk("t5_err", rsp_err, 1);
        chk("t5_hit", rsp_hit, 0);
        chk("t5_rdata", rsp_rdata, 0);
        mem_cachehit = 1'b0;
        tick();
        push(1'b0, 16'h0040, 16'h0000);
        tick();
        chk("t5_next_rd", mem_rd, 1);
        chk("t5_next_addr", mem_addr, 16'h0040);
        mem_done    = 1'b1;
        mem_dataout = 16'h4444;
        tick();
        mem_done = 1'b0;
        chk("t5_next_rdata", rsp_rdata, 16'h4444);
        chk("t5_next_err", rsp_err, 0);
        tick();

        // mem_err with Done: error response, no data, hit still reported
        push(1'b0, 16'h0060, 16'h0000);
        tick();
        mem_done     = 1'b1;
        mem_err      = 1'b1;
        mem_cachehit = 1'b1;
        mem_dataout  = 16'h7777;
        tick();
        mem_done     = 1'b0;
        mem_err      = 1'b0;
        mem_cachehit = 1'b0;
        chk("te_rsp", rsp_valid, 1);
        chk("te_err", rsp_err, 1);
        chk("te_rdata", rsp_rdata, 0);
        chk("te_hit", rsp_hit, 1);
        tick();
        chk("perf_hit_count", hit_count, PERF ? 3 : 0);
        chk("perf_miss_count", miss_count, PERF ? 3 : 0);

        // 6: reset during ACTIVE with a second request buffered
        push(1'b0, 16'h0050, 16'h0000);
        push(1'b0, 16'h0052, 16'h0000);
        chk("t6_rd_before", mem_rd, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rd_async", mem_rd, 0);
        chk("t6_rsp_async", rsp_valid, 0);
        chk("t6_hit_cleared", hit_count, 0);
        chk("t6_miss_cleared", miss_count, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || rsp_valid !== 1'b0 ||
                req_ready !== 1'b1) bad++;
            tick();
        end
        chk("t6_quiet_after_rst", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
